// File: rtl/full_adder_64bit.sv
// full_adder_64bit: 64-bit adder with carry-in and registered sum, carry-out and signed overflow.
// The adder is 16 four-bit carry-lookahead groups whose group carries ripple from one group to the next.
// Ports: clk, rst (synchronous, active-high), a[63:0], b[63:0], cin -> sum[63:0], cout, overflow.
// Options: define FULL_ADDER_64BIT_PIPE_EN to split the add into two register stages (latency 2).
// Without it there is one register stage (latency 1). Both modes give bit-identical results.
module full_adder_64bit (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout,
    output logic        overflow
);

    logic [63:0] w_opa;
    logic [63:0] w_opb;
    logic [63:0] w_sum;
    logic        w_c32;
    logic        w_c63;
    logic        w_c64;

`ifdef FULL_ADDER_64BIT_PIPE_EN
    logic [31:0] r_sum_lo;
    logic        r_c32;
    logic [31:0] r_a_hi;
    logic [31:0] r_b_hi;

    // The upper half works on operands delayed by one stage, so it lines up
    // with the carry out of the lower half registered in the previous cycle.
    assign w_opa = {r_a_hi, a[31:0]};
    assign w_opb = {r_b_hi, b[31:0]};
`else
    assign w_opa = a;
    assign w_opb = b;
`endif

    always_comb begin
        logic [3:0] v_g;
        logic [3:0] v_p;
        logic [3:0] v_c;
        logic       v_gg;
        logic       v_gp;
        logic       v_carry;
        w_sum   = '0;
        w_c32   = 1'b0;
        w_c63   = 1'b0;
        v_g     = '0;
        v_p     = '0;
        v_c     = '0;
        v_gg    = 1'b0;
        v_gp    = 1'b0;
        v_carry = cin;
        for (int g = 0; g < 16; g++) begin
            if (g == 8) begin
                w_c32 = v_carry;
`ifdef FULL_ADDER_64BIT_PIPE_EN
                v_carry = r_c32;
`endif
            end
            v_g = w_opa[4*g +: 4] & w_opb[4*g +: 4];
            v_p = w_opa[4*g +: 4] ^ w_opb[4*g +: 4];
            // Carries into each bit of the group, computed from the group's carry-in.
            v_c[0] = v_carry;
            v_c[1] = v_g[0] | (v_p[0] & v_carry);
            v_c[2] = v_g[1] | (v_p[1] & v_g[0])
                   | (v_p[1] & v_p[0] & v_carry);
            v_c[3] = v_g[2] | (v_p[2] & v_g[1])
                   | (v_p[2] & v_p[1] & v_g[0])
                   | (v_p[2] & v_p[1] & v_p[0] & v_carry);
            v_gg = v_g[3] | (v_p[3] & v_g[2])
                 | (v_p[3] & v_p[2] & v_g[1])
                 | (v_p[3] & v_p[2] & v_p[1] & v_g[0]);
            v_gp = &v_p;
            w_sum[4*g +: 4] = v_p ^ v_c;
            if (g == 15) begin
                w_c63 = v_c[3];
            end
            v_carry = v_gg | (v_gp & v_carry);
        end
        w_c64 = v_carry;
    end

`ifdef FULL_ADDER_64BIT_PIPE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum_lo <= '0;
            r_c32    <= 1'b0;
            r_a_hi   <= '0;
            r_b_hi   <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            r_sum_lo <= w_sum[31:0];
            r_c32    <= w_c32;
            r_a_hi   <= a[63:32];
            r_b_hi   <= b[63:32];
            sum      <= {w_sum[63:32], r_sum_lo};
            cout     <= w_c64;
            overflow <= w_c63 ^ w_c64;
        end
    end
`else
    logic w_unused;
    assign w_unused = w_c32;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            sum      <= w_sum;
            cout     <= w_c64;
            // Signed overflow: the carry into the sign bit differs from the carry out of it.
            overflow <= w_c63 ^ w_c64;
        end
    end
`endif

endmodule

// File: tb/tb_full_adder_64bit.sv
// tb_full_adder_64bit: directed and random checks of full_adder_64bit against a 65-bit arithmetic model.
// The model is a delay line of depth L that matches the adder's latency.
module tb_full_adder_64bit;

`ifdef FULL_ADDER_64BIT_PIPE_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] sum;
    logic        cout;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    logic [63:0] m_sum [L];
    logic        m_c   [L];
    logic        m_v   [L];
    string       m_tag [L];

    full_adder_64bit dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic edge_step(input string tag);
        logic [64:0] r;
        @(posedge clk);
        r = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        for (int i = L - 1; i > 0; i--) begin
            m_sum[i] = m_sum[i-1];
            m_c[i]   = m_c[i-1];
            m_v[i]   = m_v[i-1];
            m_tag[i] = m_tag[i-1];
        end
        m_sum[0] = r[63:0];
        m_c[0]   = r[64];
        m_v[0]   = (a[63] == b[63]) && (r[63] != a[63]);
        m_tag[0] = tag;
        if (rst) begin
            for (int i = 0; i < L; i++) begin
                m_sum[i] = '0;
                m_c[i]   = 1'b0;
                m_v[i]   = 1'b0;
                m_tag[i] = "reset";
            end
        end
        #1;
        total++;
        assert (sum === m_sum[L-1]) else begin
            bad++;
            $error("FAIL %s sum got=%h exp=%h", m_tag[L-1], sum, m_sum[L-1]);
        end
        total++;
        assert (cout === m_c[L-1]) else begin
            bad++;
            $error("FAIL %s cout got=%b exp=%b", m_tag[L-1], cout, m_c[L-1]);
        end
        total++;
        assert (overflow === m_v[L-1]) else begin
            bad++;
            $error("FAIL %s ov got=%b exp=%b", m_tag[L-1], overflow, m_v[L-1]);
        end
    endtask

    task automatic drive(input logic [63:0] ia, input logic [63:0] ib,
                         input logic ic, input string tag);
        a   = ia;
        b   = ib;
        cin = ic;
        edge_step(tag);
    endtask

    initial begin
        rst = 1'b1;
        a   = 64'h0123_4567_89AB_CDEF;
        b   = 64'hFEDC_BA98_7654_3210;
        cin = 1'b1;
        edge_step("rst_hold");
        a = $urandom();
        edge_step("rst_wins");
        rst = 1'b0;

        drive(64'h0000_0010_0000_0005, 64'h0000_0000_0100_000A, 1'b0, "mix");
        drive(64'h5, 64'hA, 1'b1, "cin1");
        drive(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, "c32");
        drive(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, "posov");
        drive(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, "negov");
        drive('1, 64'h1, 1'b0, "wrap1");
        drive('1, 64'h2, 1'b0, "wrap2");
        drive(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, "negneg");
        drive('1, '1, 1'b0, "ones");
        drive('1, '1, 1'b1, "ones_cin");
        drive('1, 64'h0, 1'b1, "cin_wrap");
        for (int i = 0; i < L; i++) begin
            drive(64'h0, 64'h0, 1'b0, "flush");
        end

        for (int i = 0; i < 200; i++) begin
            rst = (i == 100);
            drive({$urandom(), $urandom()}, {$urandom(), $urandom()},
                  1'($urandom_range(1)), "rand");
        end
        rst = 1'b0;
        for (int i = 0; i < L; i++) begin
            drive(64'h0, 64'h0, 1'b0, "flush");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
